// File: rtl/calc_sequencer.sv
// Calculator control FSM: builds decimal operands from keypad strobes, drives the ALU start/done handshake and the display.
// Optional ALU watchdog enabled by defining CALC_TIMEOUT_EN.
module calc_sequencer #(
    parameter int W              = 16,
    parameter int NDIGITS        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic         is_number,
    input  logic         is_op,
    input  logic         is_c,
    input  logic         is_equ,
    input  logic [3:0]   key_value,
    input  logic [1:0]   operator,
    output logic         alu_start,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_op,
    input  logic         alu_done,
    input  logic [W-1:0] alu_result,
    input  logic         alu_err,
    output logic [W-1:0] display_value,
    output logic         error,
    output logic         busy,
    output logic [2:0]   state_o
);

    // state  | meaning
    // S_A    | entering operand A (or after clear)
    // S_OP   | operator latched, waiting for first digit of B
    // S_B    | entering operand B
    // S_EXEC | ALU launched, waiting for done
    // S_RES  | result shown, may chain or start anew
    // S_ERR  | ALU error, only clear accepted
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_RES  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam int CW = $clog2(NDIGITS + 1);

    state_t         state, state_n;
    logic [W-1:0]   opa, opb, opa_n, opb_n;
    logic [1:0]     op_n;
    logic [CW-1:0]  count, count_n;
    logic           err_n;
    logic [W-1:0]   digit_w;
    logic           can_add;
    logic           timeout;

    assign digit_w = W'(key_value);
    assign can_add = (count < CW'(NDIGITS));
    assign alu_a   = opa;
    assign alu_b   = opb;
    assign state_o = state;

`ifdef CALC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmr;

    // Loaded on entry to S_EXEC; reaching 1 means this is the last allowed cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr <= '0;
        end else if (state != S_EXEC && state_n == S_EXEC) begin
            tmr <= TW'(TIMEOUT_CYCLES);
        end else if (state == S_EXEC && tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end

    assign timeout = (state == S_EXEC) && (tmr == TW'(1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        opa_n   = opa;
        opb_n   = opb;
        op_n    = alu_op;
        count_n = count;
        err_n   = error;
        if (key_valid && is_c) begin
            state_n = S_A;
            opa_n   = '0;
            opb_n   = '0;
            count_n = '0;
            err_n   = 1'b0;
        end else begin
            case (state)
                S_A: begin
                    if (key_valid && is_number && can_add) begin
                        opa_n   = opa * W'(10) + digit_w;
                        count_n = count + 1'b1;
                    end else if (key_valid && is_op) begin
                        op_n    = operator;
                        count_n = '0;
                        state_n = S_OP;
                    end
                end
                S_OP: begin
                    if (key_valid && is_number) begin
                        opb_n   = digit_w;
                        count_n = CW'(1);
                        state_n = S_B;
                    end else if (key_valid && is_op) begin
                        op_n = operator;
                    end
                end
                S_B: begin
                    if (key_valid && is_number && can_add) begin
                        opb_n   = opb * W'(10) + digit_w;
                        count_n = count + 1'b1;
                    end else if (key_valid && is_equ) begin
                        state_n = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (alu_done) begin
                        if (alu_err) begin
                            err_n   = 1'b1;
                            state_n = S_ERR;
                        end else begin
                            opa_n   = alu_result;
                            state_n = S_RES;
                        end
                    end else if (timeout) begin
                        err_n   = 1'b1;
                        state_n = S_ERR;
                    end
                end
                S_RES: begin
                    if (key_valid && is_number) begin
                        opa_n   = digit_w;
                        count_n = CW'(1);
                        state_n = S_A;
                    end else if (key_valid && is_op) begin
                        op_n    = operator;
                        count_n = '0;
                        state_n = S_OP;
                    end
                end
                S_ERR: begin
                end
                default: state_n = S_A;
            endcase
        end
    end

    // Outputs are registered from next-state values so they change together with state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_A;
            opa           <= '0;
            opb           <= '0;
            alu_op        <= 2'b00;
            count         <= '0;
            error         <= 1'b0;
            alu_start     <= 1'b0;
            busy          <= 1'b0;
            display_value <= '0;
        end else begin
            state     <= state_n;
            opa       <= opa_n;
            opb       <= opb_n;
            alu_op    <= op_n;
            count     <= count_n;
            error     <= err_n;
            alu_start <= (state != S_EXEC) && (state_n == S_EXEC);
            busy      <= (state_n == S_EXEC);
            case (state_n)
                S_B:     display_value <= opb_n;
                S_ERR:   display_value <= '0;
                default: display_value <= opa_n;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: key sequences with hand-computed display/handshake expectations.
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic        is_number = 1'b0;
    logic        is_op = 1'b0;
    logic        is_c = 1'b0;
    logic        is_equ = 1'b0;
    logic [3:0]  key_value = 4'd0;
    logic [1:0]  operator = 2'd0;
    logic        alu_start;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_op;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = 16'd0;
    logic        alu_err = 1'b0;
    logic [15:0] display_value;
    logic        error;
    logic        busy;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;

    calc_sequencer #(.W(16), .NDIGITS(4), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .is_number(is_number), .is_op(is_op), .is_c(is_c), .is_equ(is_equ),
        .key_value(key_value), .operator(operator),
        .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
        .display_value(display_value), .error(error), .busy(busy), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic press(input logic num, input logic op, input logic c, input logic eq,
                         input logic [3:0] kv, input logic [1:0] opr);
        key_valid = 1'b1;
        is_number = num;
        is_op     = op;
        is_c      = c;
        is_equ    = eq;
        key_value = kv;
        operator  = opr;
        tick();
        key_valid = 1'b0;
        is_number = 1'b0;
        is_op     = 1'b0;
        is_c      = 1'b0;
        is_equ    = 1'b0;
        key_value = 4'd0;
        operator  = 2'd0;
    endtask

    task automatic digit(input logic [3:0] d);
        press(1'b1, 1'b0, 1'b0, 1'b0, d, 2'd0);
    endtask

    task automatic oper(input logic [1:0] o);
        press(1'b0, 1'b1, 1'b0, 1'b0, 4'hA + {2'b00, o}, o);
    endtask

    task automatic equ;
        press(1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 2'd0);
    endtask

    task automatic clr;
        press(1'b0, 1'b0, 1'b1, 1'b0, 4'hE, 2'd0);
    endtask

    // Called right after the equ key; answers three cycles after alu_start.
    task automatic run_alu(input string tag, input logic [15:0] a_exp, input logic [15:0] b_exp,
                           input logic [1:0] op_exp, input logic [15:0] res, input logic err);
        chk({tag, "_start"}, alu_start, 1);
        chk({tag, "_a"}, alu_a, a_exp);
        chk({tag, "_b"}, alu_b, b_exp);
        chk({tag, "_op"}, alu_op, op_exp);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_state"}, state_o, 3);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk({tag, "_start_low"}, alu_start, 0);
            chk({tag, "_a_held"}, alu_a, a_exp);
            chk({tag, "_b_held"}, alu_b, b_exp);
        end
        alu_done   = 1'b1;
        alu_result = res;
        alu_err    = err;
        tick();
        alu_done   = 1'b0;
        alu_result = 16'd0;
        alu_err    = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_state", state_o, 0);
        chk("rst_disp", display_value, 0);
        chk("rst_start", alu_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", error, 0);
        chk("rst_a", alu_a, 0);
        chk("rst_op", alu_op, 0);
        rst = 1'b1;
        tick();

        // 12 + 3 = 15
        equ();
        chk("equ_in_a", state_o, 0);
        digit(4'd1);
        digit(4'd2);
        chk("t1_disp12", display_value, 12);
        oper(2'd0);
        chk("t1_state_op", state_o, 1);
        chk("t1_disp_op", display_value, 12);
        digit(4'd3);
        chk("t1_state_b", state_o, 2);
        chk("t1_disp_b", display_value, 3);
        equ();
        run_alu("t1", 16'd12, 16'd3, 2'd0, 16'd15, 1'b0);
        chk("t1_disp_res", display_value, 15);
        chk("t1_state_res", state_o, 4);
        chk("t1_busy_res", busy, 0);
        equ();
        chk("t1_equ_res", state_o, 4);

        // Chaining: 15 - 5 = 10
        oper(2'd1);
        chk("t2_state_op", state_o, 1);
        chk("t2_disp_op", display_value, 15);
        digit(4'd5);
        chk("t2_disp_b", display_value, 5);
        equ();
        run_alu("t2", 16'd15, 16'd5, 2'd1, 16'd10, 1'b0);
        chk("t2_disp_res", display_value, 10);
        chk("t2_state_res", state_o, 4);

        // Digit limit
        clr();
        chk("t3_clr_state", state_o, 0);
        chk("t3_clr_disp", display_value, 0);
        digit(4'd1);
        digit(4'd2);
        digit(4'd3);
        digit(4'd4);
        chk("t3_disp1234", display_value, 1234);
        digit(4'd5);
        chk("t3_fifth_ign", display_value, 1234);
        chk("t3_state", state_o, 0);

        // Divide by zero -> error
        clr();
        digit(4'd7);
        oper(2'd3);
        digit(4'd0);
        chk("t4_state_b", state_o, 2);
        chk("t4_disp_b", display_value, 0);
        equ();
        run_alu("t4", 16'd7, 16'd0, 2'd3, 16'd0, 1'b1);
        chk("t4_err", error, 1);
        chk("t4_state_err", state_o, 5);
        chk("t4_disp_err", display_value, 0);
        digit(4'd5);
        chk("t4_ign_state", state_o, 5);
        chk("t4_ign_err", error, 1);
        clr();
        chk("t4_clr_state", state_o, 0);
        chk("t4_clr_err", error, 0);
        chk("t4_clr_disp", display_value, 0);
        chk("t4_op_kept", alu_op, 3);

        // Clear coincident with alu_done wins
        digit(4'd2);
        oper(2'd0);
        digit(4'd3);
        equ();
        chk("t5_start", alu_start, 1);
        tick();
        key_valid  = 1'b1;
        is_c       = 1'b1;
        key_value  = 4'hE;
        alu_done   = 1'b1;
        alu_result = 16'd5;
        tick();
        key_valid  = 1'b0;
        is_c       = 1'b0;
        key_value  = 4'd0;
        alu_done   = 1'b0;
        alu_result = 16'd0;
        chk("t5_abort_state", state_o, 0);
        chk("t5_abort_disp", display_value, 0);
        chk("t5_abort_busy", busy, 0);
        alu_done   = 1'b1;
        alu_result = 16'd77;
        tick();
        alu_done   = 1'b0;
        alu_result = 16'd0;
        chk("t5_late_state", state_o, 0);
        chk("t5_late_disp", display_value, 0);
        digit(4'd6);
        chk("t5_opa_zeroed", display_value, 6);
        clr();

        // Asynchronous reset mid-entry
        digit(4'd4);
        digit(4'd2);
        chk("t6_disp42", display_value, 42);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_disp", display_value, 0);
        chk("t6_async_state", state_o, 0);
        chk("t6_async_a", alu_a, 0);
        tick();
        rst = 1'b1;
        tick();
        digit(4'd9);
        chk("t6_disp9", display_value, 9);
        chk("t6_op_reset", alu_op, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
